// File: rtl/dff_debounce_edge.sv
// Glitch filter for a raw or asynchronous level: 2-flop synchronizer, saturating stability counter,
// registered filtered level with complement, and one-cycle rise/fall pulses.
module dff_debounce_edge #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic clk,
  input  logic Reset,
  input  logic Set,
  input  logic d,
  output logic q,
  output logic n_q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYC - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             nq_q, nq_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      nq_q   <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      nq_q   <= nq_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    nq_d   = nq_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (Set) begin
      // Preset the synchronizer too so releasing Set with d high causes no spurious count.
      s1_d  = 1'b1;
      s2_d  = 1'b1;
      cnt_d = '0;
      q_d   = 1'b1;
      nq_d  = 1'b0;
    end else if (s2_q == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      q_d    = s2_q;
      nq_d   = ~s2_q;
      rise_d = s2_q;
      fall_d = ~s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign q    = q_q;
  assign n_q  = nq_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_dff_debounce_edge.sv
// Self-checking bench: default-parameter instance plus a STABLE_CYC=1 instance, checked against
// a streak-counting reference model, a vector table and hand-written corner sequences.
module tb_dff_debounce_edge;

  localparam int SC_A = 4;
  localparam int SC_B = 1;

  logic clk = 1'b0;
  logic Reset, Set, d;
  logic q1, nq1, rise1, fall1, busy1;
  logic q2, nq2, rise2, fall2, busy2;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  dff_debounce_edge #(.STABLE_CYC(SC_A), .CNT_W(3)) u_dut_a (
    .clk  (clk),
    .Reset(Reset),
    .Set  (Set),
    .d    (d),
    .q    (q1),
    .n_q  (nq1),
    .rise (rise1),
    .fall (fall1),
    .busy (busy1)
  );

  dff_debounce_edge #(.STABLE_CYC(SC_B), .CNT_W(1)) u_dut_b (
    .clk  (clk),
    .Reset(Reset),
    .Set  (Set),
    .d    (d),
    .q    (q2),
    .n_q  (nq2),
    .rise (rise2),
    .fall (fall2),
    .busy (busy2)
  );

  // Model: two-sample delay line, then q follows once sc consecutive delayed samples differ from it.
  typedef struct {
    logic s1;
    logic s2;
    logic q;
    logic rise;
    logic fall;
    int   streak;
  } model_t;

  model_t m1, m2;

  function automatic model_t model_step(model_t m, int sc, logic r, logic s, logic dd);
    model_t n = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (!r) begin
      n.s1 = 1'b0; n.s2 = 1'b0; n.q = 1'b0; n.streak = 0;
    end else if (s) begin
      n.s1 = 1'b1; n.s2 = 1'b1; n.q = 1'b1; n.streak = 0;
    end else begin
      n.s1 = dd;
      n.s2 = m.s1;
      if (m.s2 == m.q) begin
        n.streak = 0;
      end else if (m.streak + 1 >= sc) begin
        n.q = m.s2; n.rise = m.s2; n.fall = !m.s2; n.streak = 0;
      end else begin
        n.streak = m.streak + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, update models at the edge, compare both DUTs at the falling edge.
  task automatic cycle(input logic r, input logic s, input logic dd);
    Reset = r; Set = s; d = dd;
    @(posedge clk);
    m1 = model_step(m1, SC_A, r, s, dd);
    m2 = model_step(m2, SC_B, r, s, dd);
    @(negedge clk);
    chk("a_q", q1, m1.q);
    chk("a_nq", nq1, !m1.q);
    chk("a_rise", rise1, m1.rise);
    chk("a_fall", fall1, m1.fall);
    chk("a_busy", busy1, m1.streak != 0);
    chk("b_q", q2, m2.q);
    chk("b_nq", nq2, !m2.q);
    chk("b_rise", rise2, m2.rise);
    chk("b_fall", fall2, m2.fall);
    chk("b_busy", busy2, m2.streak != 0);
  endtask

  // Holds d at val and reports the edge (1-based) at which each q first equals val; 0 = never.
  task automatic run_until(input logic val, output int e1, output int e2);
    e1 = 0;
    e2 = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 1'b0, val);
      if (e1 == 0 && q1 == val) e1 = k;
      if (e2 == 0 && q2 == val) e2 = k;
    end
  endtask

  typedef struct {
    logic r, s, d;
    logic q, nq, rise, fall, busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int e1, e2;
    bit saw_busy, saw_rise, saw_rise2, saw_fall2;
    Reset = 1'b0; Set = 1'b0; d = 1'b0;
    m1 = '{s1: 1'b0, s2: 1'b0, q: 1'b0, rise: 1'b0, fall: 1'b0, streak: 0};
    m2 = m1;

    // Reset with d high, then release: q rises after edge 6.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].d);
      chk("tbl_q", q1, tbl[i].q);
      chk("tbl_nq", nq1, tbl[i].nq);
      chk("tbl_rise", rise1, tbl[i].rise);
      chk("tbl_fall", fall1, tbl[i].fall);
      chk("tbl_busy", busy1, tbl[i].busy);
    end

    // Glitch of 3 cycles is rejected by the slow filter.
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    saw_busy = 0; saw_rise = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, (i < 3) ? 1'b1 : 1'b0);
      if (busy1) saw_busy = 1;
      if (rise1) saw_rise = 1;
    end
    chk("glitch_busy_seen", saw_busy, 1'b1);
    chk("glitch_no_rise", saw_rise, 1'b0);
    chk("glitch_q_low", q1, 1'b0);

    // One-cycle glitch passes through the STABLE_CYC=1 instance only.
    saw_rise = 0; saw_rise2 = 0; saw_fall2 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0);
      if (rise1) saw_rise = 1;
      if (rise2) saw_rise2 = 1;
      if (fall2) saw_fall2 = 1;
    end
    chk("glitch1_a_no_rise", saw_rise, 1'b0);
    chk("glitch1_b_rise", saw_rise2, 1'b1);
    chk("glitch1_b_fall", saw_fall2, 1'b1);

    // Step latency: edge 6 vs edge 3.
    run_until(1'b1, e1, e2);
    chk_int("step_lat_a", e1, SC_A + 2);
    chk_int("step_lat_b", e2, SC_B + 2);

    // Bounce 1/0/1/0 then settle low: fall 6 edges after the settle sample.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    run_until(1'b0, e1, e2);
    chk_int("bounce_lat_a", e1, SC_A + 2);

    // Reset beats Set; Set presets without a pulse; release with d low falls after edge 6.
    cycle(1'b0, 1'b1, 1'b0);
    chk("prio_q", q1, 1'b0);
    chk("prio_nq", nq1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("set_q", q1, 1'b1);
    chk("set_nq", nq1, 1'b0);
    chk("set_no_rise", rise1, 1'b0);
    run_until(1'b0, e1, e2);
    chk_int("set_rel_lat_a", e1, SC_A + 2);
    chk_int("set_rel_lat_b", e2, SC_B + 2);

    // Mid-count abort by Set at edge 4.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("abort_set_q", q1, 1'b1);
    chk("abort_set_busy", busy1, 1'b0);
    chk("abort_set_rise", rise1, 1'b0);
    saw_rise = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (rise1) saw_rise = 1;
    end
    chk("abort_set_no_rise_after", saw_rise, 1'b0);

    // Mid-count abort by Reset at edge 4.
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    chk("abort_rst_pending", busy1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("abort_rst_q", q1, 1'b0);
    chk("abort_rst_busy", busy1, 1'b0);
    chk("abort_rst_rise", rise1, 1'b0);

    // Random runs with occasional Reset/Set, checked against the model each cycle.
    for (int n = 0; n < 300; n++) begin
      logic dv;
      int len;
      dv = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 63) == 0), dv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
